// File: rtl/spi_slave.sv
// ============================================================================
// Module  : spi_slave
// Brief   : SPI slave, mode CPOL=0/CPHA=1, MSB first, 8-bit frames, with
//           synchronized pins. Optional macro SPI_SLAVE_MISO_TRI_EN tri-states
//           miso while idle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spi_slave (
  input  logic       clk,
  input  logic       rst,
  input  logic       ss,
  input  logic       sck,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       new_data,
  output logic       busy
);

  localparam logic [0:0] c_idle   = 1'b0;
  localparam logic [0:0] c_active = 1'b1;

  logic       ss_s1_q, ss_s2_q, ss_s3_q, ss_s1_d, ss_s2_d, ss_s3_d;
  logic       sck_s1_q, sck_s2_q, sck_s3_q, sck_s1_d, sck_s2_d, sck_s3_d;
  logic       mosi_s1_q, mosi_s2_q, mosi_s1_d, mosi_s2_d;
  logic       rst_dly_q, rst_dly_d;
  logic       ss_arm_q, ss_arm_d;
  logic [0:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] data_out_q, data_out_d;
  logic       new_data_q, new_data_d;
  logic       miso_q, miso_d;

  logic       w_ss_fall, w_ss_rise, w_sck_rise, w_sck_fall;
  logic [7:0] w_rx_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      ss_s1_q    <= 1'b1;
      ss_s2_q    <= 1'b1;
      ss_s3_q    <= 1'b1;
      sck_s1_q   <= 1'b0;
      sck_s2_q   <= 1'b0;
      sck_s3_q   <= 1'b0;
      mosi_s1_q  <= 1'b0;
      mosi_s2_q  <= 1'b0;
      rst_dly_q  <= 1'b1;
      ss_arm_q   <= 1'b0;
      state_q    <= c_idle;
      cnt_q      <= 3'd0;
      tx_q       <= 8'h00;
      rx_q       <= 8'h00;
      data_out_q <= 8'h00;
      new_data_q <= 1'b0;
      miso_q     <= 1'b0;
    end else begin
      ss_s1_q    <= ss_s1_d;
      ss_s2_q    <= ss_s2_d;
      ss_s3_q    <= ss_s3_d;
      sck_s1_q   <= sck_s1_d;
      sck_s2_q   <= sck_s2_d;
      sck_s3_q   <= sck_s3_d;
      mosi_s1_q  <= mosi_s1_d;
      mosi_s2_q  <= mosi_s2_d;
      rst_dly_q  <= rst_dly_d;
      ss_arm_q   <= ss_arm_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      new_data_q <= new_data_d;
      miso_q     <= miso_d;
    end
  end

  always_comb begin
    ss_s1_d   = ss;
    ss_s2_d   = ss_s1_q;
    ss_s3_d   = ss_s2_q;
    sck_s1_d  = sck;
    sck_s2_d  = sck_s1_q;
    sck_s3_d  = sck_s2_q;
    mosi_s1_d = mosi;
    mosi_s2_d = mosi_s1_q;
    rst_dly_d = 1'b0;
    // ss falls are honoured only after a genuine high pin sample since reset,
    // so an ss held low through reset cannot restart the aborted frame.
    ss_arm_d  = ss_arm_q | (~rst_dly_q & ss_s1_q);
  end

  assign w_ss_fall  = ss_arm_q & ss_s3_q & ~ss_s2_q;
  assign w_ss_rise  = ~ss_s3_q & ss_s2_q;
  assign w_sck_rise = ~sck_s3_q & sck_s2_q;
  assign w_sck_fall = sck_s3_q & ~sck_s2_q;
  assign w_rx_next  = {rx_q[6:0], mosi_s2_q};

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    new_data_d = 1'b0;
    miso_d     = miso_q;
    case (state_q)
      c_idle: begin
        if (w_ss_fall) begin
          state_d = c_active;
          tx_d    = data_in;
          cnt_d   = 3'd0;
          rx_d    = 8'h00;
          miso_d  = 1'b0;
        end
      end
      c_active: begin
        // ss release takes priority over any sck edge seen in the same cycle.
        if (w_ss_rise) begin
          state_d = c_idle;
          cnt_d   = 3'd0;
          miso_d  = 1'b0;
        end else if (w_sck_rise) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end else if (w_sck_fall) begin
          rx_d  = w_rx_next;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            data_out_d = w_rx_next;
            new_data_d = 1'b1;
            tx_d       = data_in;
          end
        end
      end
      default: state_d = c_idle;
    endcase
  end

  always_comb begin
    busy     = (state_q == c_active);
    new_data = new_data_q;
    data_out = data_out_q;
`ifdef SPI_SLAVE_MISO_TRI_EN
    miso     = (state_q == c_active) ? miso_q : 1'bz;
`else
    miso     = (state_q == c_active) ? miso_q : 1'b0;
`endif
  end

endmodule

`default_nettype wire

// File: tb/tb_spi_slave.sv
// ============================================================================
// Module  : tb_spi_slave
// Brief   : Directed self-checking bench for spi_slave acting as SPI master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_spi_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss = 1'b1;
  logic       sck = 1'b0;
  logic       mosi = 1'b0;
  logic       miso;
  logic [7:0] data_in = 8'h00;
  logic [7:0] data_out;
  logic       new_data;
  logic       busy;

`ifdef SPI_SLAVE_MISO_TRI_EN
  localparam logic c_miso_idle = 1'bz;
`else
  localparam logic c_miso_idle = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int nd_count = 0;
  logic [7:0] nd_last = 8'h00;

  spi_slave u_dut (
    .clk      (clk),
    .rst      (rst),
    .ss       (ss),
    .sck      (sck),
    .mosi     (mosi),
    .miso     (miso),
    .data_in  (data_in),
    .data_out (data_out),
    .new_data (new_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (new_data) begin
      nd_count++;
      nd_last = data_out;
    end
  end

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    else
      n_pass++;
  endtask

  task automatic ss_low(input int half, input bit chk);
    ss = 1'b0;
    repeat (2) @(negedge clk);
    if (chk) check("busy_before_ss_fall_plus3", {7'd0, busy}, 8'd0);
    @(negedge clk);
    if (chk) check("busy_at_ss_fall_plus3", {7'd0, busy}, 8'd1);
    repeat (half - 3) @(negedge clk);
  endtask

  task automatic ss_high(input int half, input bit chk);
    ss = 1'b1;
    repeat (2) @(negedge clk);
    if (chk) check("busy_before_ss_rise_plus3", {7'd0, busy}, 8'd1);
    @(negedge clk);
    if (chk) check("busy_at_ss_rise_plus3", {7'd0, busy}, 8'd0);
    repeat (half + 3) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, input int half,
                          output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b1;
      mosi = tx[7-i];
      repeat (half) @(negedge clk);
      rx  = {rx[6:0], miso};
      sck = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rx;
    int         nd0;
    bit         saw_busy;
    bit         saw_nd;

    repeat (4) @(negedge clk);
    check("rst_busy", {7'd0, busy}, 8'd0);
    check("rst_new_data", {7'd0, new_data}, 8'd0);
    check("rst_data_out", data_out, 8'h00);
    check("rst_miso", {7'd0, miso}, {7'd0, c_miso_idle});
    rst = 1'b0;
    repeat (6) @(negedge clk);

    // Single byte exchange
    data_in = 8'hA5;
    nd0 = nd_count;
    ss_low(4, 1'b1);
    spi_bits(8'h3C, 8, 4, rx);
    check("single_rx", rx, 8'hA5);
    check("single_data_out", data_out, 8'h3C);
    check("single_nd_count", 8'(nd_count - nd0), 8'd1);
    ss_high(4, 1'b1);

    // Two-byte frame with data_in changed mid-byte
    data_in = 8'h12;
    nd0 = nd_count;
    ss_low(4, 1'b0);
    data_in = 8'h34;
    spi_bits(8'hF0, 8, 4, rx);
    check("two_rx0", rx, 8'h12);
    check("two_nd_last0", nd_last, 8'hF0);
    spi_bits(8'h0F, 8, 4, rx);
    check("two_rx1", rx, 8'h34);
    check("two_nd_last1", nd_last, 8'h0F);
    check("two_nd_count", 8'(nd_count - nd0), 8'd2);
    ss_high(4, 1'b0);

    // Abort after 5 bits, then a full frame
    data_in = 8'hC3;
    nd0 = nd_count;
    ss_low(4, 1'b0);
    spi_bits(8'hFF, 5, 4, rx);
    ss_high(4, 1'b1);
    check("abort_nd_count", 8'(nd_count - nd0), 8'd0);
    check("abort_data_out", data_out, 8'h0F);
    ss_low(4, 1'b0);
    spi_bits(8'h81, 8, 4, rx);
    check("after_abort_rx", rx, 8'hC3);
    check("after_abort_data_out", data_out, 8'h81);
    check("after_abort_nd_count", 8'(nd_count - nd0), 8'd1);
    ss_high(4, 1'b0);

    // Reset mid-frame with ss kept low
    data_in = 8'h55;
    nd0 = nd_count;
    ss_low(4, 1'b0);
    spi_bits(8'hE7, 3, 4, rx);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", {7'd0, busy}, 8'd0);
    check("midrst_new_data", {7'd0, new_data}, 8'd0);
    check("midrst_data_out", data_out, 8'h00);
    check("midrst_miso", {7'd0, miso}, {7'd0, c_miso_idle});
    spi_bits(8'hE7, 5, 4, rx);
    check("midrst_nd_count", 8'(nd_count - nd0), 8'd0);
    check("midrst_busy_after", {7'd0, busy}, 8'd0);
    check("midrst_data_out_after", data_out, 8'h00);
    ss = 1'b1;
    repeat (8) @(negedge clk);

    // sck pulses while idle
    nd0 = nd_count;
    saw_busy = 1'b0;
    saw_nd = 1'b0;
    for (int i = 0; i < 16; i++) begin
      sck = 1'b1;
      repeat (4) begin
        @(negedge clk);
        saw_busy |= busy;
        saw_nd   |= new_data;
      end
      sck = 1'b0;
      repeat (4) begin
        @(negedge clk);
        saw_busy |= busy;
        saw_nd   |= new_data;
      end
    end
    check("idle_busy", {7'd0, saw_busy}, 8'd0);
    check("idle_new_data", {7'd0, saw_nd}, 8'd0);
    check("idle_nd_count", 8'(nd_count - nd0), 8'd0);
    check("idle_miso", {7'd0, miso}, {7'd0, c_miso_idle});

    // Slow sck, half-period 10 clk
    data_in = 8'h5A;
    nd0 = nd_count;
    ss_low(10, 1'b1);
    spi_bits(8'h5A, 8, 10, rx);
    check("slow_rx", rx, 8'h5A);
    check("slow_data_out", data_out, 8'h5A);
    check("slow_nd_count", 8'(nd_count - nd0), 8'd1);
    ss_high(10, 1'b1);
    check("final_miso", {7'd0, miso}, {7'd0, c_miso_idle});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 The block SHALL have no parameters; SPI mode SHALL be fixed at CPOL=0, CPHA=1, MSB first, 8-bit frames.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous to clk and active-high.
REQ-004 ss  input  1  slave select from the master, active-low, asynchronous to clk.
REQ-005 sck  input  1  SPI clock from the master, asynchronous to clk, idles low.
REQ-006 mosi  input  1  serial data from the master, asynchronous to clk.
REQ-007 miso  output  1  serial data to the master.
REQ-008 data_in  input  8  byte to transmit; sampled at frame start and at each byte completion.
REQ-009 data_out  output  8  last fully received byte.
REQ-010 new_data  output  1  one-clk pulse; data_out updated in the same cycle.
REQ-011 busy  output  1  high while a frame is selected (state ACTIVE).

Function
REQ-012 ss, sck and mosi SHALL each pass through a 2-flop synchronizer; ss and sck SHALL have a third flop for edge detection.
REQ-013 An sck rise/fall or ss fall/rise SHALL be detected as a one-clk event exactly 3 clk cycles after the pin transition.
REQ-014 Correct operation SHALL require sck high and low phases of at least 4 clk cycles each; faster sck is unsupported, with no recovery requirement.
REQ-015 The FSM SHALL have exactly two states, IDLE and ACTIVE.
REQ-016 IDLE -> ACTIVE on a synchronized ss fall: load tx_shift from data_in, clear bit counter, clear rx_shift.
REQ-017 In ACTIVE, on a synchronized sck rise: miso <= tx_shift[7] and tx_shift shifts left by one.
REQ-018 In ACTIVE, on a synchronized sck fall: rx_shift <= {rx_shift[6:0], mosi_sync} and the 3-bit counter increments.
REQ-019 On the sck fall with counter==7: data_out <= {rx_shift[6:0], mosi_sync} and new_data=1 in the next clk cycle.
REQ-020 On that same sck fall, the counter SHALL wrap to 0 and tx_shift SHALL reload from data_in, giving back-to-back multi-byte frames with no gap.
REQ-021 ACTIVE -> IDLE on a synchronized ss rise; a partial byte SHALL be discarded, with no new_data and data_out unchanged.
REQ-022 If an ss rise and an sck edge are detected in the same cycle, ss SHALL win and the sck edge SHALL be ignored.
REQ-023 sck edges while IDLE SHALL be ignored.
REQ-024 miso SHALL hold its value between rising edges; in IDLE, miso SHALL be 0 (see REQ-029 for the alternative).
REQ-025 data_out SHALL retain its value until the next completed byte.

Reset
REQ-026 On rst: state IDLE, busy=0, new_data=0, data_out=8'h00, miso=0, counter=0, shift registers=0.
REQ-027 On rst, ss synchronizer flops SHALL reset to 1 and sck/mosi flops to 0, so no spurious edge is seen after reset.
REQ-028 rst asserted mid-frame SHALL abort the frame with no new_data; a new frame SHALL start only on a later ss fall.

Configuration
REQ-029 With macro SPI_SLAVE_MISO_TRI_EN defined, miso SHALL be 1'bz whenever state is IDLE and driven as in REQ-017 in ACTIVE; without it, miso SHALL be driven 0 in IDLE.

Verification
REQ-030 Single byte, sck half-period 4 clk: data_in=8'hA5, master sends 8'h3C -> master receives 8'hA5; data_out=8'h3C with one new_data pulse; busy high from ss fall+3 to ss rise+3.
REQ-031 Two-byte frame: data_in=8'h12, then changed to 8'h34 before byte 1 ends; master sends 8'hF0,8'h0F -> master receives 8'h12,8'h34; two new_data pulses with data_out 8'hF0 then 8'h0F.
REQ-032 Abort: ss released after 5 bits of 8'hFF -> no new_data, data_out keeps previous value, busy falls; next full frame 8'h81 received correctly.
REQ-033 Reset mid-frame: rst pulsed after 3 bits -> all outputs at reset values; the same ss-low frame's remaining bits produce no new_data.
REQ-034 Edges while IDLE: 16 sck pulses with ss high -> busy=0 and no new_data throughout; miso=0, or z with SPI_SLAVE_MISO_TRI_EN.
REQ-035 Long sck (half-period 10 clk) with 8'h5A in both directions -> exchanged bytes correct and new_data asserted exactly once.
